// File: rtl/twiddle_fetch_ctrl.sv
// twiddle_fetch_ctrl: sequences twiddle ROM reads for a radix-2 DIT FFT and streams tagged coefficients
// Ports: clk_i/reset_n_i (sync active-low); cfg_len_log2_i/start_i launch a run of length 2^L;
// busy_o/done_o/err_o report run status; rom_addr_o/rom_addr_valid_o issue reads and
// rom_data_i/rom_data_valid_i return them one cycle later; tw_* is the valid/ready coefficient
// stream tagged with stage, butterfly index and last flag.
module twiddle_fetch_ctrl #(
  parameter int MAX_FFT_LENGTH_LOG2 = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [3:0]  cfg_len_log2_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] rom_addr_o,
  output logic        rom_addr_valid_o,
  input  logic [31:0] rom_data_i,
  input  logic        rom_data_valid_i,
  output logic [31:0] tw_data_o,
  output logic [3:0]  tw_stage_o,
  output logic [15:0] tw_bfly_o,
  output logic        tw_last_o,
  output logic        tw_valid_o,
  input  logic        tw_ready_i
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t      state_q;
  logic [3:0]  len_q, s_q, sb_s_q;
  logic [15:0] b_q, sb_b_q, b_max;
  logic        sb_last_q, inflight_q, inflight_d, err_q;
  logic [52:0] mem_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_d;
  logic        start_ok, last_bfly, last_iss, issue, push, pop;
  logic [31:0] addr_w;
  logic [52:0] head;
  always_comb begin
    start_ok = cfg_len_log2_i != 4'd0 && !(5'(cfg_len_log2_i) > 5'(MAX_FFT_LENGTH_LOG2));
    b_max = 16'((17'd1 << (len_q - 4'd1)) - 17'd1);
    last_bfly = b_q == b_max;
    last_iss = last_bfly && s_q == len_q - 4'd1;
    pop = count_q != 2'd0 && tw_ready_i;
    push = rom_data_valid_i && inflight_q;
    // Credit counts this cycle's pop as freed space so a ready sink sees one coefficient per cycle;
    // an issued read lands one cycle later, by which time the popped slot is free.
    issue = state_q == RUN && (3'(count_q) - 3'(pop) + 3'(inflight_q) < 3'(FIFO_DEPTH));
    addr_w = (32'(b_q) & ((32'd1 << s_q) - 32'd1)) << (5'(MAX_FFT_LENGTH_LOG2 - 1) - 5'(s_q));
    inflight_d = issue || (inflight_q && !rom_data_valid_i);
    count_d = count_q + 2'(push) - 2'(pop);
    head = mem_q[rd_ptr_q];
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      len_q <= '0;
      s_q <= '0;
      b_q <= '0;
      sb_s_q <= '0;
      sb_b_q <= '0;
      sb_last_q <= 1'b0;
      inflight_q <= 1'b0;
      err_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q <= '0;
    end else begin
      err_q <= state_q == IDLE && start_i && !start_ok;
      inflight_q <= inflight_d;
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {rom_data_i, sb_s_q, sb_b_q, sb_last_q};
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (issue) begin
        sb_s_q <= s_q;
        sb_b_q <= b_q;
        sb_last_q <= last_iss;
        b_q <= last_bfly ? 16'd0 : b_q + 16'd1;
        s_q <= last_bfly ? s_q + 4'd1 : s_q;
      end
      unique case (state_q)
        IDLE: if (start_i && start_ok) begin
          len_q <= cfg_len_log2_i;
          s_q <= '0;
          b_q <= '0;
          state_q <= RUN;
        end
        RUN: if (issue && last_iss) state_q <= DRAIN;
        // Look at next-cycle occupancy so done lands exactly one cycle after the last handshake.
        DRAIN: if (count_d == 2'd0 && !inflight_d) state_q <= DONE;
        DONE: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign err_o = err_q;
  assign rom_addr_valid_o = issue;
  assign rom_addr_o = issue ? addr_w[15:0] : 16'd0;
  assign tw_valid_o = count_q != 2'd0;
  assign {tw_data_o, tw_stage_o, tw_bfly_o, tw_last_o} = tw_valid_o ? head : '0;
endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
// tb_twiddle_fetch_ctrl: scoreboard bench for the twiddle fetch controller with a 1-cycle ROM model
module tb_twiddle_fetch_ctrl;
  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [3:0]  cfg_len_log2_i = '0;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, err_o, rom_addr_valid_o;
  logic [15:0] rom_addr_o;
  logic [31:0] rom_data_i = '0;
  logic        rom_data_valid_i = 1'b0;
  logic [31:0] tw_data_o;
  logic [3:0]  tw_stage_o;
  logic [15:0] tw_bfly_o;
  logic        tw_last_o, tw_valid_o;
  logic        tw_ready_i = 1'b1;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic [15:0] b;
    logic        l;
  } ent_t;

  ent_t        exp_q[$];
  logic [15:0] addr_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          stall_mode = 0;
  int          stall_left = 0;
  int          occ = 0;
  bit          exp_done = 0;
  bit          prev_stall = 0;
  ent_t        prev_e, cur;

  always #5 clk_i = ~clk_i;

  twiddle_fetch_ctrl #(.MAX_FFT_LENGTH_LOG2(12), .FIFO_DEPTH(2)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .cfg_len_log2_i(cfg_len_log2_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rom_addr_o(rom_addr_o), .rom_addr_valid_o(rom_addr_valid_o),
    .rom_data_i(rom_data_i), .rom_data_valid_i(rom_data_valid_i),
    .tw_data_o(tw_data_o), .tw_stage_o(tw_stage_o), .tw_bfly_o(tw_bfly_o),
    .tw_last_o(tw_last_o), .tw_valid_o(tw_valid_o), .tw_ready_i(tw_ready_i)
  );

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  always @(posedge clk_i) begin
    rom_data_valid_i <= rom_addr_valid_o;
    rom_data_i <= rom_word(rom_addr_o);
  end

  always @(posedge clk_i) begin
    #1;
    if (!stall_mode) tw_ready_i = 1'b1;
    else if (stall_left > 0) begin
      tw_ready_i = 1'b0;
      stall_left--;
    end else if ($urandom_range(0, 7) == 0) begin
      tw_ready_i = 1'b0;
      stall_left = 9;
    end else tw_ready_i = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk_i) begin
    cur = {tw_data_o, tw_stage_o, tw_bfly_o, tw_last_o};
    if (rom_addr_valid_o) begin
      if (addr_q.size() == 0) chk("extra_rom_read", 64'(rom_addr_o), 64'hFFFF_FFFF);
      else chk("rom_addr", 64'(rom_addr_o), 64'(addr_q.pop_front()));
    end
    if (prev_stall) begin
      chk("stall_valid", 64'(tw_valid_o), 64'd1);
      chk("stall_stable", 64'(cur), 64'(prev_e));
    end
    if (done_o || exp_done) chk("done_timing", 64'(done_o), 64'(exp_done));
    exp_done = 0;
    if (tw_valid_o && tw_ready_i) begin
      if (exp_q.size() == 0) chk("extra_coef", 64'(cur), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("coef", 64'(cur), 64'(exp_q.pop_front()));
      exp_done = tw_last_o;
    end
    if (stall_mode) begin
      occ += int'(rom_data_valid_i) - int'(tw_valid_o && tw_ready_i);
      chk("occupancy_over_2", 64'(occ > 2), 64'd0);
    end
    prev_stall = tw_valid_o && !tw_ready_i;
    prev_e = cur;
  end

  task automatic load_expect(input int l);
    for (int s = 0; s < l; s++)
      for (int b = 0; b < (1 << (l - 1)); b++) begin
        logic [15:0] a;
        a = 16'((b & ((1 << s) - 1)) * (2048 >> s));
        addr_q.push_back(a);
        exp_q.push_back({rom_word(a), 4'(s), 16'(b), s == l - 1 && b == (1 << (l - 1)) - 1});
      end
  endtask

  task automatic pulse_start(input int l);
    @(posedge clk_i);
    #1 cfg_len_log2_i = 4'(l);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic check_latency();
    int n;
    n = 1;
    @(negedge clk_i);
    chk("busy_after_start", 64'(busy_o), 64'd1);
    chk("first_read_cycle1", 64'(rom_addr_valid_o), 64'd1);
    while (!tw_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("first_valid_latency", 64'(n), 64'd3);
  endtask

  task automatic run(input int l, input bit restart, input bit start_on_done);
    int n;
    load_expect(l);
    occ = 0;
    pulse_start(l);
    check_latency();
    if (restart) begin
      pulse_start(5);
      chk("busy_during_restart", 64'(busy_o), 64'd1);
    end
    n = 0;
    while (!done_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk("done_seen", 64'(done_o), 64'd1);
    if (start_on_done) begin
      cfg_len_log2_i = 4'd2;
      start_i = 1'b1;
      @(posedge clk_i);
      #1 start_i = 1'b0;
      repeat (3) begin
        @(negedge clk_i);
        chk("start_on_done_ignored", 64'(busy_o), 64'd0);
      end
    end else @(negedge clk_i);
    chk("coef_left", 64'(exp_q.size()), 64'd0);
    chk("addr_left", 64'(addr_q.size()), 64'd0);
  endtask

  task automatic err_case(input int l);
    pulse_start(l);
    @(negedge clk_i);
    chk("err_pulse", 64'(err_o), 64'd1);
    chk("err_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    chk("err_single", 64'(err_o), 64'd0);
    chk("err_busy2", 64'(busy_o), 64'd0);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {busy_o, done_o, err_o, rom_addr_o, rom_addr_valid_o, tw_valid_o, tw_last_o},
        64'd0);
    chk({name, "_tw"}, {tw_data_o, tw_stage_o, tw_bfly_o}, 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset_outs");
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    run(2, 0, 0);
    run(4, 0, 1);
    stall_mode = 1;
    run(3, 0, 0);
    stall_mode = 0;
    repeat (2) @(posedge clk_i);
    err_case(0);
    err_case(13);
    run(3, 1, 0);
    load_expect(3);
    pulse_start(3);
    check_latency();
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b0;
    @(posedge clk_i);
    #1 exp_q.delete();
    addr_q.delete();
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check_all_zero("midrun_reset_outs");
    @(negedge clk_i);
    chk("stale_data_ignored", 64'(tw_valid_o), 64'd0);
    run(2, 0, 0);
    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
